// File: rtl/t5_mdsq_if.sv
// Decode-side operand bus and result/stall return path of the M-extension sequencer.
// The pipeline side is the master; the sequencer is the slave.
interface t5_mdsq_if #(
    parameter int XLEN = 32
);
    logic            sena;
    logic [4:0]      dopc;
    logic [6:0]      dfn7;
    logic [2:0]      dfn3;
    logic [XLEN-1:0] dop1;
    logic [XLEN-1:0] dop2;
    logic            xstl;
    logic [XLEN-1:0] xmdr;
    logic            xmdv;

    // No valid/ready handshake: an M op is accepted in any IDLE cycle with sena high,
    // the pipeline is held through xstl, and xmdv marks the single result cycle.
    modport master (
        output sena, dopc, dfn7, dfn3, dop1, dop2,
        input  xstl, xmdr, xmdv
    );

    modport slave (
        input  sena, dopc, dfn7, dfn3, dop1, dop2,
        output xstl, xmdr, xmdv
    );
endinterface

// File: rtl/t5_mdsq.sv
// RV32M multiply/divide sequencer: 1 bit/cycle shift-add multiply and restoring divide,
// with magnitude conversion at start and sign correction in a FIX cycle.
module t5_mdsq #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic       sclk,
    input  logic       srst,
    t5_mdsq_if.slave   bus,
    output logic [1:0] state_dbg
);
    localparam int CW = $clog2(ITER);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [2:0]        f3_q;
    logic              neg_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   res_q;

    logic              is_m, strt, op_div, a_sgn, b_sgn, sa, sb, neg_in;
    logic              div0, ovf, special;
    logic [XLEN-1:0]   a_abs, b_abs, special_res;
    logic              unused_dfn7;

    always_comb begin
        is_m    = (bus.dopc == 5'h0C) && bus.dfn7[0];
        strt    = (state == IDLE) && bus.sena && is_m;
        op_div  = bus.dfn3[2];
        a_sgn   = op_div ? !bus.dfn3[0] : (bus.dfn3 == 3'd1 || bus.dfn3 == 3'd2);
        b_sgn   = op_div ? !bus.dfn3[0] : (bus.dfn3 == 3'd1);
        sa      = a_sgn && bus.dop1[XLEN-1];
        sb      = b_sgn && bus.dop2[XLEN-1];
        a_abs   = sa ? -bus.dop1 : bus.dop1;
        b_abs   = sb ? -bus.dop2 : bus.dop2;
        // Remainder follows the dividend; product and quotient follow the sign difference.
        neg_in  = (op_div && bus.dfn3[1]) ? sa : (sa ^ sb);
        div0    = op_div && (bus.dop2 == '0);
        ovf     = op_div && !bus.dfn3[0] && (bus.dop1 == {1'b1, {(XLEN-1){1'b0}}})
                  && (bus.dop2 == '1);
        special = div0 || ovf;
        if (div0)
            special_res = bus.dfn3[1] ? bus.dop1 : '1;
        else
            special_res = bus.dfn3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    assign unused_dfn7 = ^bus.dfn7[6:1];

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_sh;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
        // Partial remainder lives in the high word, dividend/quotient bits in the low word.
        div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_ge   = div_sh >= {1'b0, b_q};
        div_rem  = div_ge ? (div_sh[XLEN-1:0] - b_q) : div_sh[XLEN-1:0];
        div_next = {div_rem, acc[XLEN-2:0], div_ge};
        prod     = neg_q ? -acc : acc;
        quo      = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem      = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (f3_q)
            3'd0:       fix_res = prod[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       fix_res = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5: fix_res = quo;
            default:    fix_res = rem;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            state <= IDLE;
            cnt   <= '0;
            f3_q  <= '0;
            neg_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            res_q <= '0;
        end else if (bus.sena) begin
            case (state)
                IDLE: begin
                    if (strt) begin
                        f3_q  <= bus.dfn3;
                        neg_q <= neg_in;
                        a_q   <= a_abs;
                        b_q   <= b_abs;
                        acc   <= {{XLEN{1'b0}}, op_div ? a_abs : b_abs};
                        cnt   <= '0;
                        if (special) begin
                            res_q <= special_res;
                            state <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc <= f3_q[2] ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1))
                        state <= FIX;
                end
                FIX: begin
                    res_q <= fix_res;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.xstl = !srst && (strt || state == BUSY || state == FIX);
    assign bus.xmdv = (state == DONE);
    assign bus.xmdr = res_q;
    assign state_dbg = state;
endmodule

// File: tb/tb_t5_mdsq.sv
// Directed bench for t5_mdsq: one task per feature, inline comparisons against
// hand-computed results, latencies and stall counts.
module tb_t5_mdsq;
    logic       sclk = 1'b0;
    logic       srst;
    logic [1:0] state_dbg;
    int         total = 0;
    int         bad = 0;

    t5_mdsq_if bus ();

    t5_mdsq dut (
        .sclk      (sclk),
        .srst      (srst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 sclk = ~sclk;

    task automatic clear_op();
        bus.dopc = 5'h00;
        bus.dfn7 = 7'h00;
        bus.dfn3 = 3'd0;
        bus.dop1 = '0;
        bus.dop2 = '0;
    endtask

    // Presents one M op for a single cycle and watches it to completion.
    // pause_at/pause_len drop sena for that many cycles starting at cycle pause_at.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int pause_at, input int pause_len,
                          output int lat, output int stalls, output logic [31:0] res,
                          output logic late_v);
        lat = -1;
        stalls = 0;
        res = '0;
        @(negedge sclk);
        bus.dopc = 5'h0C;
        bus.dfn7 = 7'h01;
        bus.dfn3 = f3;
        bus.dop1 = a;
        bus.dop2 = b;
        for (int c = 0; c < 200; c++) begin
            bus.sena = !(c >= pause_at && c < pause_at + pause_len);
            #1;
            if (bus.xstl) stalls++;
            if (bus.xmdv) begin
                lat = c;
                res = bus.xmdr;
            end
            @(posedge sclk);
            #1;
            clear_op();
            @(negedge sclk);
            if (lat >= 0) break;
        end
        bus.sena = 1'b1;
        #1;
        late_v = bus.xmdv;
    endtask

    task automatic test_reset();
        srst = 1'b1;
        bus.sena = 1'b1;
        clear_op();
        repeat (2) @(posedge sclk);
        @(negedge sclk);
        total++;
        if (bus.xmdr !== 32'h0) begin bad++; $display("FAIL reset_xmdr: got %h want %h", bus.xmdr, 32'h0); end
        total++;
        if (bus.xmdv !== 1'b0) begin bad++; $display("FAIL reset_xmdv: got %b want 0", bus.xmdv); end
        total++;
        if (state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
        bus.dopc = 5'h0C;
        bus.dfn7 = 7'h01;
        #1;
        total++;
        if (bus.xstl !== 1'b0) begin bad++; $display("FAIL reset_xstl: got %b want 0", bus.xstl); end
        @(negedge sclk);
        clear_op();
        srst = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat, stalls;
        logic [31:0] res;
        logic late_v;
        run_op(f3, a, b, -1, 0, lat, stalls, res, late_v);
        total++;
        if (res !== exp_res) begin bad++; $display("FAIL %s_res: got %h want %h", name, res, exp_res); end
        total++;
        if (lat != exp_lat) begin bad++; $display("FAIL %s_lat: got %0d want %0d", name, lat, exp_lat); end
        total++;
        if (stalls != exp_lat) begin bad++; $display("FAIL %s_stall: got %0d want %0d", name, stalls, exp_lat); end
        total++;
        if (late_v !== 1'b0) begin bad++; $display("FAIL %s_pulse: got %b want 0", name, late_v); end
    endtask

    task automatic test_mul();
        check_op("mul_7x6", 3'd0, 32'd7, 32'd6, 32'd42, 34);
        check_op("mul_neg", 3'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 34);
        check_op("mulh", 3'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 34);
        check_op("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        check_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 34);
    endtask

    task automatic test_div();
        check_op("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
        check_op("rem_m7_2", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
        check_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 34);
        check_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 34);
        check_op("div_7_m2", 3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34);
        check_op("rem_7_m2", 3'd6, 32'd7, 32'hFFFFFFFE, 32'd1, 34);
    endtask

    task automatic test_special();
        check_op("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        check_op("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5, 1);
        check_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        check_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
    endtask

    task automatic test_sena_hold();
        int lat, stalls;
        logic [31:0] res;
        logic late_v;
        run_op(3'd0, 32'd7, 32'd6, 10, 5, lat, stalls, res, late_v);
        total++;
        if (res !== 32'd42) begin bad++; $display("FAIL hold_res: got %h want %h", res, 32'd42); end
        total++;
        if (lat != 39) begin bad++; $display("FAIL hold_lat: got %0d want 39", lat); end
        total++;
        if (stalls != 39) begin bad++; $display("FAIL hold_stall: got %0d want 39", stalls); end
    endtask

    task automatic test_abort();
        int seen_v, seen_s;
        @(negedge sclk);
        bus.sena = 1'b1;
        bus.dopc = 5'h0C;
        bus.dfn7 = 7'h01;
        bus.dfn3 = 3'd0;
        bus.dop1 = 32'd123;
        bus.dop2 = 32'd456;
        @(posedge sclk);
        #1;
        clear_op();
        repeat (9) @(negedge sclk);
        srst = 1'b1;
        #1;
        total++;
        if (bus.xstl !== 1'b0) begin bad++; $display("FAIL abort_xstl: got %b want 0", bus.xstl); end
        @(negedge sclk);
        srst = 1'b0;
        seen_v = 0;
        seen_s = 0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (bus.xmdv) seen_v++;
            if (bus.xstl) seen_s++;
            @(negedge sclk);
        end
        total++;
        if (seen_v != 0) begin bad++; $display("FAIL abort_no_pulse: got %0d want 0", seen_v); end
        total++;
        if (seen_s != 0) begin bad++; $display("FAIL abort_no_stall: got %0d want 0", seen_s); end
        total++;
        if (state_dbg !== 2'd0) begin bad++; $display("FAIL abort_state: got %0d want 0", state_dbg); end
        check_op("after_abort", 3'd5, 32'd100, 32'd7, 32'd14, 34);
    endtask

    task automatic test_non_m();
        int seen_v, seen_s;
        seen_v = 0;
        seen_s = 0;
        @(negedge sclk);
        bus.sena = 1'b1;
        bus.dopc = 5'h0C;
        bus.dfn7 = 7'h00;
        bus.dfn3 = 3'd0;
        bus.dop1 = 32'd9;
        bus.dop2 = 32'd9;
        for (int c = 0; c < 10; c++) begin
            if (c == 5) begin
                bus.dopc = 5'h04;
                bus.dfn7 = 7'h01;
            end
            #1;
            if (bus.xmdv) seen_v++;
            if (bus.xstl) seen_s++;
            @(negedge sclk);
        end
        clear_op();
        total++;
        if (seen_s != 0) begin bad++; $display("FAIL nonm_xstl: got %0d want 0", seen_s); end
        total++;
        if (seen_v != 0) begin bad++; $display("FAIL nonm_xmdv: got %0d want 0", seen_v); end
        total++;
        if (bus.xmdr !== 32'd14) begin bad++; $display("FAIL nonm_hold: got %h want %h", bus.xmdr, 32'd14); end
    endtask

    task automatic test_back_to_back();
        int first_v, second_v;
        logic stl34, stl35;
        logic [31:0] res2;
        first_v = -1;
        second_v = -1;
        stl34 = 1'b1;
        stl35 = 1'b0;
        res2 = '0;
        @(negedge sclk);
        bus.sena = 1'b1;
        bus.dopc = 5'h0C;
        bus.dfn7 = 7'h01;
        bus.dfn3 = 3'd0;
        bus.dop1 = 32'd3;
        bus.dop2 = 32'd5;
        for (int c = 0; c < 70; c++) begin
            #1;
            if (c == 34) stl34 = bus.xstl;
            if (c == 35) stl35 = bus.xstl;
            if (bus.xmdv) begin
                if (first_v < 0) first_v = c;
                else if (second_v < 0) begin
                    second_v = c;
                    res2 = bus.xmdr;
                end
            end
            if (c == 69) clear_op();
            @(negedge sclk);
        end
        clear_op();
        repeat (40) @(negedge sclk);
        total++;
        if (first_v != 34) begin bad++; $display("FAIL b2b_first: got %0d want 34", first_v); end
        total++;
        if (stl34 !== 1'b0) begin bad++; $display("FAIL b2b_done_xstl: got %b want 0", stl34); end
        total++;
        if (stl35 !== 1'b1) begin bad++; $display("FAIL b2b_restart_xstl: got %b want 1", stl35); end
        total++;
        if (second_v != 69) begin bad++; $display("FAIL b2b_second: got %0d want 69", second_v); end
        total++;
        if (res2 !== 32'd15) begin bad++; $display("FAIL b2b_res: got %h want %h", res2, 32'd15); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_sena_hold();
        test_abort();
        test_non_m();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
